// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   - pll_sup_state_t : supervisor FSM state encoding
//   - *_DEF constants : default timing parameters (50 MHz reference clock)
//   - cnt_width()     : width of the shared state counter
// -----------------------------------------------------------------------------
package pll_sup_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_sup_state_t;

  // 1 ms of stable lock, 10 ms lock-acquisition limit, 16-cycle PLL reset
  localparam int STABLE_CYCLES_DEF  = 50000;
  localparam int LOCK_TIMEOUT_DEF   = 500000;
  localparam int PLL_RST_CYCLES_DEF = 16;

  // The counter only ever reaches (limit - 1), so clog2(limit) bits suffice.
  // Never narrower than one bit so a limit of 1 still yields a legal vector.
  function automatic int cnt_width(input int lock_timeout, input int stable_cycles);
    int m;
    int w;
    m = (lock_timeout > stable_cycles) ? lock_timeout : stable_cycles;
    w = $clog2(m);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// N-stage single-bit synchronizer for an asynchronous level input.
// Ports:
//   clk       : destination clock
//   rst       : synchronous active-high reset, clears every stage to 0
//   async_bit : asynchronous input level
//   sync_bit  : synchronized level, STAGES clk cycles behind async_bit
// -----------------------------------------------------------------------------
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_bit,
  output logic sync_bit
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_bit};
    end
  end

  assign sync_bit = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Drives the PLL reset, watches the (asynchronous) PLL lock flag and only
// releases the downstream system reset once lock has been continuously
// present for STABLE_CYCLES refclk cycles. Lock losses while running are
// counted (saturating) and lock-acquisition timeouts raise a sticky flag.
//
// Ports:
//   refclk        : reference clock, the only clock of the block
//   rst           : synchronous active-high reset
//   pll_locked    : PLL lock indication, asynchronous to refclk
//   pll_rst       : reset to the PLL, active-high, registered
//   sys_rst       : downstream system reset, active-high, registered
//   ready         : high only while running, registered
//   lock_loss_cnt : saturating count of lock losses seen while running
//   timeout_err   : sticky lock-acquisition timeout flag
//
// Build option:
//   PLL_AUTO_RELOCK_EN  defined   -> lock loss and timeout both restart the
//                                    PLL through a fresh pll_rst pulse.
//                       undefined -> pll_rst is only pulsed after rst; lock
//                                    loss returns to waiting for lock and a
//                                    timeout just flags and re-arms.
// -----------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = STABLE_CYCLES_DEF,
  parameter int LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
  parameter int PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic             timeout_err
);

  // A single synchronizer flop is not metastability-safe; never build fewer than two.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // The shared counter also times the reset pulse, so it must cover that too.
  localparam int CW = cnt_width(LOCK_TIMEOUT,
                                (STABLE_CYCLES > PLL_RST_CYCLES) ? STABLE_CYCLES
                                                                 : PLL_RST_CYCLES);

  localparam logic [CW-1:0]    RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_MAX    = '1;

  logic           locked_s;
  pll_sup_state_t state;
  pll_sup_state_t state_nx;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nx;
  logic [CNT_W-1:0] loss_nx;
  logic           timeout_nx;

  bit_sync #(
    .STAGES    (SYNC_N)
  ) u_lock_sync (
    .clk       (refclk),
    .rst       (rst),
    .async_bit (pll_locked),
    .sync_bit  (locked_s)
  );

  // State, counter and output registers. Outputs are decoded from the next
  // state so they change on the same edge as the state itself.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= RESET_PLL;
      cnt           <= '0;
      lock_loss_cnt <= '0;
      timeout_err   <= 1'b0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      lock_loss_cnt <= loss_nx;
      timeout_err   <= timeout_nx;
      pll_rst       <= (state_nx == RESET_PLL);
      sys_rst       <= (state_nx != RUN);
      ready         <= (state_nx == RUN);
    end
  end

  // Next-state logic. cnt counts cycles spent in the current state and is
  // forced to zero whenever the state changes.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    loss_nx    = lock_loss_cnt;
    timeout_nx = timeout_err;

    unique case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_nx = WAIT_LOCK;
        end
      end

      WAIT_LOCK: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (locked_s) begin
          state_nx = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_nx = 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
          state_nx   = RESET_PLL;
`else
          cnt_nx     = '0;
`endif
        end
      end

      STABLE: begin
        // A drop here is a failed qualification, not a lock loss: no count.
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nx = RUN;
        end
      end

      RUN: begin
        // Nothing is timed while running; hold cnt so it cannot wrap.
        cnt_nx = cnt;
        if (!locked_s) begin
          if (lock_loss_cnt != LOSS_MAX) begin
            loss_nx = lock_loss_cnt + 1'b1;
          end
`ifdef PLL_AUTO_RELOCK_EN
          state_nx = RESET_PLL;
`else
          state_nx = WAIT_LOCK;
`endif
        end
      end

      default: begin
        state_nx = RESET_PLL;
      end
    endcase

    if (state_nx != state) begin
      cnt_nx = '0;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with SYNC_STAGES=2, STABLE_CYCLES=8,
// LOCK_TIMEOUT=32, PLL_RST_CYCLES=4, CNT_W=8. A timestamp-based model of the
// supervisor is compared against the DUT on every falling edge; directed
// scenarios add hand-computed latency and count expectations.
// Honours PLL_AUTO_RELOCK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int SS = 2;
  localparam int S  = 8;
  localparam int T  = 32;
  localparam int P  = 4;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES    (SS),
    .STABLE_CYCLES  (S),
    .LOCK_TIMEOUT   (T),
    .PLL_RST_CYCLES (P),
    .CNT_W          (8)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt),
    .timeout_err   (timeout_err)
  );

  always #5 refclk = ~refclk;

  // ---------------------------------------------------------------------------
  // Model: phase 0 = PLL held in reset, 1 = waiting for lock, 2 = qualifying
  // lock, 3 = running. Each phase remembers the edge it began on (t0); the
  // lock level the supervisor acts on at edge n is the pll_locked value
  // sampled SS edges earlier, or 0 if that sample predates the last rst.
  // ---------------------------------------------------------------------------
  bit lk [0:131071];
  int cyc      = 0;
  int t0       = 0;
  int last_rst = -100;
  int ph       = 0;
  int losses   = 0;
  bit terr     = 1'b0;
  bit m_valid  = 1'b0;
  bit e_pll_rst, e_sys_rst, e_ready;

  always @(posedge refclk) begin
    int n;
    int dwell;
    bit ls;
    n = cyc;
    lk[n] = pll_locked;
    if (rst) begin
      ph       = 0;
      t0       = n;
      losses   = 0;
      terr     = 1'b0;
      last_rst = n;
      m_valid  = 1'b1;
    end else begin
      ls    = (n - SS > last_rst) ? lk[n-SS] : 1'b0;
      dwell = n - t0;
      case (ph)
        0: begin
          if (dwell == P) begin ph = 1; t0 = n; end
        end
        1: begin
          if (ls) begin
            ph = 2; t0 = n;
          end else if (dwell == T) begin
            terr = 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
            ph = 0;
`endif
            t0 = n;
          end
        end
        2: begin
          if (!ls) begin
            ph = 1; t0 = n;
          end else if (dwell == S) begin
            ph = 3; t0 = n;
          end
        end
        default: begin
          if (!ls) begin
            if (losses < 255) losses++;
`ifdef PLL_AUTO_RELOCK_EN
            ph = 0;
`else
            ph = 1;
`endif
            t0 = n;
          end
        end
      endcase
    end
    e_pll_rst = (ph == 0);
    e_sys_rst = (ph != 3);
    e_ready   = (ph == 3);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge refclk) begin
    if (m_valid) begin
      chk("model_pll_rst", pll_rst, e_pll_rst);
      chk("model_sys_rst", sys_rst, e_sys_rst);
      chk("model_ready", ready, e_ready);
      chk("model_lock_loss_cnt", lock_loss_cnt, losses);
      chk("model_timeout_err", timeout_err, terr);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input int k);
    repeat (k) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // sel: 0 = ready, 1 = timeout_err. n returns the number of edges waited.
  task automatic wait_sig(input int sel, input bit want, input int limit, output int n);
    bit v;
    n = 0;
    while (1) begin
      v = (sel == 0) ? ready : timeout_err;
      if (v == want) break;
      if (n >= limit) begin
        total++;
        bad++;
        $display("FAIL wait_sel%0d: level %0b not reached within %0d cycles", sel, want, limit);
        break;
      end
      step(1);
      n++;
    end
  endtask

  task automatic lose_and_relock();
    int n;
    pll_locked = 1'b0;
    wait_sig(0, 1'b0, 20, n);
    pll_locked = 1'b1;
    wait_sig(0, 1'b1, 100, n);
  endtask

  initial begin
    int n;
    int hi;
    int rel;

    rst        = 1'b1;
    pll_locked = 1'b0;
    step(3);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_lock_loss_cnt", lock_loss_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);

    // Basic bring-up: 4-cycle PLL reset, release 2+1+8 cycles after lock.
    rst = 1'b0;
    hi  = 0;
    for (int i = 0; i < 10; i++) begin
      if (pll_rst) hi++;
      step(1);
    end
    chk("pll_rst_width", hi, 4);
    pll_locked = 1'b1;
    wait_sig(0, 1'b1, 100, n);
    chk("release_latency", n, 11);
    chk("release_sys_rst", sys_rst, 0);

    // Short lock glitch must not release; second rise releases 11 cycles later.
    rst = 1'b1;
    pll_locked = 1'b0;
    step(2);
    rst = 1'b0;
    step(6);
    pll_locked = 1'b1;
    rel = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) pll_locked = 1'b0;
      if (ready) rel++;
      step(1);
    end
    chk("glitch_ready_cycles", rel, 0);
    chk("glitch_lock_loss_cnt", lock_loss_cnt, 0);
    pll_locked = 1'b1;
    wait_sig(0, 1'b1, 100, n);
    chk("glitch_release_latency", n, 11);

    // Lock loss while running.
    pll_locked = 1'b0;
    wait_sig(0, 1'b0, 20, n);
    chk("loss_latency", n, 3);
    chk("loss_sys_rst", sys_rst, 1);
    chk("loss_cnt_one", lock_loss_cnt, 1);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (pll_rst) hi++;
      step(1);
    end
`ifdef PLL_AUTO_RELOCK_EN
    chk("loss_pll_rst_pulse", hi, 4);
`else
    chk("loss_pll_rst_pulse", hi, 0);
`endif
    pll_locked = 1'b1;
    wait_sig(0, 1'b1, 100, n);
    chk("relock_latency", n, 11);

    // Lock never arrives: timeout 4 + 32 cycles after rst falls.
    rst = 1'b1;
    pll_locked = 1'b0;
    step(2);
    rst = 1'b0;
    wait_sig(1, 1'b1, 100, n);
    chk("timeout_latency", n, 36);
`ifdef PLL_AUTO_RELOCK_EN
    chk("timeout_pll_rst", pll_rst, 1);
`else
    chk("timeout_pll_rst", pll_rst, 0);
`endif
    step(5);
    chk("timeout_sticky", timeout_err, 1);

    // Saturation of the lock-loss counter.
    pll_locked = 1'b1;
    wait_sig(0, 1'b1, 200, n);
    for (int i = 0; i < 300; i++) begin
      lose_and_relock();
      if (i == 9)   chk("loss_cnt_10", lock_loss_cnt, 10);
      if (i == 254) chk("loss_cnt_255", lock_loss_cnt, 255);
    end
    chk("loss_cnt_saturated", lock_loss_cnt, 255);
    chk("timeout_still_sticky", timeout_err, 1);

    // rst in the middle of RUN clears everything on the next cycle.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    pll_locked = 1'b1;
    wait_sig(0, 1'b1, 100, n);
    for (int i = 0; i < 3; i++) lose_and_relock();
    chk("pre_rst_loss_cnt", lock_loss_cnt, 3);
    chk("pre_rst_ready", ready, 1);
    rst = 1'b1;
    step(1);
    chk("midrun_sys_rst", sys_rst, 1);
    chk("midrun_pll_rst", pll_rst, 1);
    chk("midrun_ready", ready, 0);
    chk("midrun_lock_loss_cnt", lock_loss_cnt, 0);
    chk("midrun_timeout_err", timeout_err, 0);
    rst = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
